// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// pointer width and the round-robin pointer advance function.
package uart_tx_arbiter_pkg;

    localparam int PTR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

    // Index after idx, wrapping at num_req; gives the highest-priority requester.
    function automatic logic [PTR_W-1:0] rr_next_index(input logic [PTR_W-1:0] idx,
                                                       input int unsigned num_req);
        logic [PTR_W:0] nxt;
        nxt = {1'b0, idx} + {{PTR_W{1'b0}}, 1'b1};
        if (32'(nxt) >= num_req) begin
            return '0;
        end else begin
            return nxt[PTR_W-1:0];
        end
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational one-hot round-robin picker: the first set bit of req at or
// after index ptr, searching upward with wrap-around.
module uart_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner
);

    logic [NUM_REQ-1:0] rot_s;
    logic [NUM_REQ-1:0] first_s;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot_s   = NUM_REQ'({req, req} >> ptr);
        first_s = rot_s & (~rot_s + {{(NUM_REQ-1){1'b0}}, 1'b1});
        winner  = NUM_REQ'(({first_s, first_s} << ptr) >> NUM_REQ);
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that gives one requester at a time whole-message
// ownership of a single UART transmitter, with a stall timeout.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_vld,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_rdy,
    output logic [NUM_REQ-1:0]            grant,
    output logic [DATA_WIDTH-1:0]         tx_din,
    output logic                          tx_din_vld,
    input  logic                          tx_rfd,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_t             state_r;
    logic                   last_flag_r;
    logic [PTR_W-1:0]       last_granted_r;
    logic [CNT_W-1:0]       to_cnt_r;

    logic [PTR_W-1:0]       ptr_s;
    logic [NUM_REQ-1:0]     pick_s;
    logic [PTR_W-1:0]       grant_idx_s;
    logic [DATA_WIDTH-1:0]  sel_data_s;
    logic                   sel_vld_s;
    logic                   sel_last_s;

    assign ptr_s = rr_next_index(last_granted_r, NUM_REQ);

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req_vld),
        .ptr    (ptr_s),
        .winner (pick_s)
    );

    // Select the owner's byte, valid and last through the one-hot grant.
    always_comb begin
        grant_idx_s = '0;
        sel_data_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_idx_s = grant_idx_s | (PTR_W'(i) & {PTR_W{grant[i]}});
            sel_data_s  = sel_data_s |
                          (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
        end
        sel_vld_s  = |(req_vld & grant);
        sel_last_s = |(req_last & grant);
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            grant          <= '0;
            req_rdy        <= '0;
            tx_din_vld     <= 1'b0;
            tx_din         <= '0;
            busy           <= 1'b0;
            timeout_err    <= 1'b0;
            last_flag_r    <= 1'b0;
            to_cnt_r       <= '0;
            last_granted_r <= PTR_W'(NUM_REQ - 1);
        end else begin
            req_rdy     <= '0;
            tx_din_vld  <= 1'b0;
            timeout_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (|req_vld) begin
                        grant    <= pick_s;
                        busy     <= 1'b1;
                        to_cnt_r <= '0;
                        state_r  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_rfd && sel_vld_s) begin
                        req_rdy     <= grant;
                        tx_din_vld  <= 1'b1;
                        tx_din      <= sel_data_s;
                        last_flag_r <= sel_last_s;
                        state_r     <= ST_WAIT_ACK;
                    end else if (!sel_vld_s) begin
                        // Only owner starvation counts; a busy UART is not a stall.
                        if (to_cnt_r == TO_LAST) begin
                            timeout_err    <= 1'b1;
                            grant          <= '0;
                            busy           <= 1'b0;
                            last_granted_r <= grant_idx_s;
                            to_cnt_r       <= '0;
                            state_r        <= ST_IDLE;
                        end else begin
                            to_cnt_r <= to_cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    if (!tx_rfd) begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (tx_rfd) begin
                        if (last_flag_r) begin
                            grant          <= '0;
                            busy           <= 1'b0;
                            last_granted_r <= grant_idx_s;
                            state_r        <= ST_IDLE;
                        end else begin
                            to_cnt_r <= '0;
                            state_r  <= ST_SEND;
                        end
                    end
                end
                default: begin
                    grant   <= '0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: behavioural UART and requester models
// advanced once per cycle, with per-scenario tasks checking hand-derived results.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_vld = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_last = '0;
    logic [NR-1:0]     req_rdy;
    logic [NR-1:0]     grant;
    logic [DW-1:0]     tx_din;
    logic              tx_din_vld;
    logic              tx_rfd = 1'b1;
    logic              busy;
    logic              timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int viol = 0;

    logic [7:0]    mdata [NR][4];
    logic [3:0]    mlast [NR];
    int            mlen [NR];
    int            mpos [NR];
    logic [NR-1:0] men = '0;
    logic [NR-1:0] rdy_prev = '0;

    int uart_hi = 0;
    int uart_lo = 0;
    int hi_left = 0;
    int lo_left = 0;
    logic strobe_prev = 1'b0;

    logic [7:0]    log_data [64];
    logic [NR-1:0] log_grant [64];
    int            log_cyc [64];
    int            n_log = 0;

    uart_tx_arbiter #(
        .NUM_REQ     (NR),
        .DATA_WIDTH  (DW),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (req_vld),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_rdy     (req_rdy),
        .grant       (grant),
        .tx_din      (tx_din),
        .tx_din_vld  (tx_din_vld),
        .tx_rfd      (tx_rfd),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            if (men[i] && mpos[i] < mlen[i]) begin
                req_vld[i]            = 1'b1;
                req_data[i*DW +: DW]  = mdata[i][mpos[i]];
                req_last[i]           = mlast[i][mpos[i]];
            end else begin
                req_vld[i]  = 1'b0;
                req_last[i] = 1'b0;
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            mlen[i] = 0;
            mpos[i] = 0;
        end
        men         = '0;
        rdy_prev    = '0;
        req_vld     = '0;
        req_data    = '0;
        req_last    = '0;
        tx_rfd      = 1'b1;
        hi_left     = 0;
        lo_left     = 0;
        strobe_prev = 1'b0;
    endtask

    task automatic load_msg(input int r, input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input logic [3:0] lastm);
        mdata[r][0] = b0;
        mdata[r][1] = b1;
        mdata[r][2] = b2;
        mdata[r][3] = b3;
        mlast[r]    = lastm;
        mlen[r]     = n;
        mpos[r]     = 0;
        men[r]      = 1'b1;
    endtask

    // Advance one clock, then play the UART and the requesters for the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (tx_din_vld) begin
            if (tx_rfd !== 1'b1 || strobe_prev || req_rdy !== grant) viol++;
            log_data[n_log]  = tx_din;
            log_grant[n_log] = grant;
            log_cyc[n_log]   = cyc;
            n_log++;
            hi_left = uart_hi;
            lo_left = uart_lo;
        end else begin
            if (req_rdy !== '0) viol++;
            if (hi_left > 0) begin
                hi_left--;
                tx_rfd = 1'b1;
            end else if (lo_left > 0) begin
                lo_left--;
                tx_rfd = 1'b0;
            end else begin
                tx_rfd = 1'b1;
            end
        end
        strobe_prev = tx_din_vld;
        for (int i = 0; i < NR; i++) begin
            if (rdy_prev[i]) mpos[i]++;
        end
        rdy_prev = req_rdy;
        drive_reqs();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_clear();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        model_clear();
        tick();
        tick();
        tick();
        checks += 6;
        if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: got %b expected 0000", grant); end
        if (req_rdy !== 4'b0000) begin errors++; $display("FAIL rst_rdy: got %b expected 0000", req_rdy); end
        if (tx_din_vld !== 1'b0) begin errors++; $display("FAIL rst_din_vld: got %b expected 0", tx_din_vld); end
        if (tx_din !== 8'h00) begin errors++; $display("FAIL rst_din: got %h expected 00", tx_din); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b expected 0", timeout_err); end
        rst = 1'b0;
        tick();
        tick();
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
        if (grant !== 4'b0000) begin errors++; $display("FAIL idle_grant: got %b expected 0000", grant); end
    endtask

    task automatic test_single();
        int base;
        int vld_cyc;
        int bad;
        logic [7:0] exp_b [3];
        exp_b   = '{8'h41, 8'h42, 8'h43};
        base    = n_log;
        vld_cyc = -1;
        bad     = 0;
        uart_hi = 0;
        uart_lo = 10;
        load_msg(1, 3, 8'h41, 8'h42, 8'h43, 8'h00, 4'b0100);
        for (int k = 0; k < 300 && !(n_log >= base + 3 && !busy); k++) begin
            tick();
            if (vld_cyc < 0 && req_vld[1]) vld_cyc = cyc;
            if (busy && grant !== 4'b0010) bad++;
        end
        checks++;
        if (n_log < base + 3 || busy) begin
            errors++;
            $display("FAIL single_done: got %0d strobes expected 3", n_log - base);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks += 2;
                if (log_data[base+k] !== exp_b[k]) begin
                    errors++; $display("FAIL single_data%0d: got %h expected %h", k, log_data[base+k], exp_b[k]);
                end
                if (log_grant[base+k] !== 4'b0010) begin
                    errors++; $display("FAIL single_grant%0d: got %b expected 0010", k, log_grant[base+k]);
                end
            end
            checks++;
            if (log_cyc[base] !== vld_cyc + 2) begin
                errors++; $display("FAIL latency: got %0d expected %0d", log_cyc[base] - vld_cyc, 2);
            end
        end
        checks += 2;
        if (bad != 0) begin errors++; $display("FAIL single_hold: got %0d bad cycles expected 0", bad); end
        if (grant !== 4'b0000) begin errors++; $display("FAIL single_release: got %b expected 0000", grant); end
    endtask

    task automatic test_round_robin();
        int base;
        apply_reset();
        base    = n_log;
        uart_hi = 0;
        uart_lo = 3;
        for (int i = 0; i < NR; i++) begin
            load_msg(i, 2, {4'(i), 4'h0}, {4'(i), 4'h1}, 8'h00, 8'h00, 4'b0011);
        end
        for (int k = 0; k < 600 && !(n_log >= base + 8 && !busy); k++) tick();
        checks++;
        if (n_log < base + 8) begin
            errors++; $display("FAIL rr_done: got %0d strobes expected 8", n_log - base);
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks += 2;
                if (log_grant[base+k] !== (4'b0001 << (k % 4))) begin
                    errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, log_grant[base+k], 4'b0001 << (k % 4));
                end
                if (log_data[base+k] !== {4'(k % 4), 4'(k / 4)}) begin
                    errors++; $display("FAIL rr_data%0d: got %h expected %h", k, log_data[base+k], {4'(k % 4), 4'(k / 4)});
                end
            end
        end
    endtask

    task automatic test_no_preempt();
        int base;
        int bad;
        apply_reset();
        base    = n_log;
        bad     = 0;
        uart_lo = 4;
        load_msg(0, 2, 8'hA0, 8'hA1, 8'h00, 8'h00, 4'b0010);
        for (int k = 0; k < 100 && n_log < base + 1; k++) tick();
        load_msg(2, 1, 8'hC0, 8'h00, 8'h00, 8'h00, 4'b0001);
        for (int k = 0; k < 200 && !(n_log >= base + 3 && !busy); k++) begin
            tick();
            if (n_log < base + 2 && grant !== 4'b0001) bad++;
        end
        checks += 2;
        if (bad != 0) begin errors++; $display("FAIL np_hold: got %0d bad cycles expected 0", bad); end
        if (n_log < base + 3) begin
            errors++; $display("FAIL np_done: got %0d strobes expected 3", n_log - base);
        end else begin
            checks += 3;
            if (log_grant[base+1] !== 4'b0001 || log_data[base+1] !== 8'hA1) begin
                errors++; $display("FAIL np_second: got %b/%h expected 0001/a1", log_grant[base+1], log_data[base+1]);
            end
            if (log_grant[base+2] !== 4'b0100) begin
                errors++; $display("FAIL np_next_grant: got %b expected 0100", log_grant[base+2]);
            end
            if (log_data[base+2] !== 8'hC0) begin
                errors++; $display("FAIL np_next_data: got %h expected c0", log_data[base+2]);
            end
        end
    endtask

    task automatic test_timeout();
        int base;
        int s_cyc;
        int to_cyc;
        int bad;
        apply_reset();
        uart_lo = 2;
        load_msg(0, 1, 8'h05, 8'h00, 8'h00, 8'h00, 4'b0001);
        for (int k = 0; k < 100 && !(n_log >= 1 + n_log - 1 && n_log > 0 && !busy && mpos[0] == 1); k++) tick();
        base = n_log;
        bad  = 0;
        load_msg(3, 1, 8'h33, 8'h00, 8'h00, 8'h00, 4'b0000);
        for (int k = 0; k < 50 && n_log < base + 1; k++) tick();
        s_cyc  = (n_log > base) ? log_cyc[base] : 0;
        to_cyc = -1;
        for (int k = 0; k < 100 && !timeout_err; k++) begin
            tick();
            if (!timeout_err && grant !== 4'b1000) bad++;
        end
        if (timeout_err) to_cyc = cyc;
        checks += 5;
        if (n_log < base + 1 || log_grant[base] !== 4'b1000) begin
            errors++; $display("FAIL to_first_grant: got %b expected 1000", log_grant[base]);
        end
        if (to_cyc != s_cyc + 20) begin
            errors++; $display("FAIL to_pulse_cycle: got %0d expected %0d", to_cyc - s_cyc, 20);
        end
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL to_release: got %b/%b expected 0000/0", grant, busy);
        end
        if (bad != 0) begin errors++; $display("FAIL to_hold: got %0d bad cycles expected 0", bad); end
        if (n_log !== base + 1) begin errors++; $display("FAIL to_no_byte: got %0d strobes expected 1", n_log - base); end
        tick();
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b expected 0", timeout_err); end
        men[3] = 1'b0;
        load_msg(1, 1, 8'h51, 8'h00, 8'h00, 8'h00, 4'b0001);
        load_msg(2, 1, 8'h52, 8'h00, 8'h00, 8'h00, 4'b0001);
        load_msg(0, 1, 8'h50, 8'h00, 8'h00, 8'h00, 4'b0001);
        for (int k = 0; k < 300 && !(n_log >= base + 4 && !busy); k++) tick();
        checks++;
        if (n_log < base + 4) begin
            errors++; $display("FAIL to_after_done: got %0d strobes expected 4", n_log - base);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (log_grant[base+1+k] !== (4'b0001 << k) || log_data[base+1+k] !== {4'h5, 4'(k)}) begin
                    errors++;
                    $display("FAIL to_after%0d: got %b/%h expected %b/%h", k, log_grant[base+1+k],
                             log_data[base+1+k], 4'b0001 << k, {4'h5, 4'(k)});
                end
            end
        end
    endtask

    task automatic test_rfd_hold();
        int base;
        base    = n_log;
        uart_hi = 2;
        uart_lo = 3;
        load_msg(1, 2, 8'h71, 8'h72, 8'h00, 8'h00, 4'b0010);
        for (int k = 0; k < 200 && !(n_log >= base + 2 && !busy); k++) tick();
        checks++;
        if (n_log < base + 2) begin
            errors++; $display("FAIL hold_done: got %0d strobes expected 2", n_log - base);
        end else begin
            checks += 2;
            if (log_cyc[base+1] !== log_cyc[base] + 8) begin
                errors++; $display("FAIL hold_gap: got %0d expected %0d", log_cyc[base+1] - log_cyc[base], 8);
            end
            if (log_data[base] !== 8'h71 || log_data[base+1] !== 8'h72) begin
                errors++; $display("FAIL hold_data: got %h %h expected 71 72", log_data[base], log_data[base+1]);
            end
        end
        uart_hi = 0;
    endtask

    task automatic test_reset_mid();
        int base;
        base    = n_log;
        uart_lo = 6;
        load_msg(2, 4, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 4'b1000);
        for (int k = 0; k < 200 && n_log < base + 2; k++) tick();
        for (int k = 0; k < 4; k++) tick();
        checks += 2;
        if (busy !== 1'b1 || grant !== 4'b0100) begin
            errors++; $display("FAIL mid_state: got %b/%b expected 1/0100", busy, grant);
        end
        if (n_log !== base + 2) begin errors++; $display("FAIL mid_count: got %0d expected 2", n_log - base); end
        rst = 1'b1;
        #1;
        checks += 6;
        if (grant !== 4'b0000) begin errors++; $display("FAIL mid_rst_grant: got %b expected 0000", grant); end
        if (req_rdy !== 4'b0000) begin errors++; $display("FAIL mid_rst_rdy: got %b expected 0000", req_rdy); end
        if (tx_din_vld !== 1'b0) begin errors++; $display("FAIL mid_rst_din_vld: got %b expected 0", tx_din_vld); end
        if (tx_din !== 8'h00) begin errors++; $display("FAIL mid_rst_din: got %h expected 00", tx_din); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL mid_rst_timeout: got %b expected 0", timeout_err); end
        model_clear();
        tick();
        rst = 1'b0;
        base = n_log;
        load_msg(0, 1, 8'hD0, 8'h00, 8'h00, 8'h00, 4'b0001);
        load_msg(2, 1, 8'hD2, 8'h00, 8'h00, 8'h00, 4'b0001);
        for (int k = 0; k < 200 && !(n_log >= base + 2 && !busy); k++) tick();
        checks++;
        if (n_log < base + 2) begin
            errors++; $display("FAIL mid_after_done: got %0d strobes expected 2", n_log - base);
        end else begin
            checks += 2;
            if (log_grant[base] !== 4'b0001 || log_data[base] !== 8'hD0) begin
                errors++; $display("FAIL mid_after_first: got %b/%h expected 0001/d0", log_grant[base], log_data[base]);
            end
            if (log_grant[base+1] !== 4'b0100 || log_data[base+1] !== 8'hD2) begin
                errors++; $display("FAIL mid_after_second: got %b/%h expected 0100/d2", log_grant[base+1], log_data[base+1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_no_preempt();
        test_timeout();
        test_rfd_hold();
        test_reset_mid();
        checks++;
        if (viol != 0) begin
            errors++; $display("FAIL strobe_rules: got %0d violations expected 0", viol);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
